main_nios2_processor_oci_dct_sequencer: RTL and testbench



---
 rtl/main_nios2_processor_oci_dct_pkg.sv | 15 +
 rtl/main_nios2_processor_oci_dct_outslot.sv | 36 +++
 rtl/main_nios2_processor_oci_dct_sequencer.sv | 108 ++++++++++
 tb/tb_main_nios2_processor_oci_dct_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/main_nios2_processor_oci_dct_pkg.sv
// Shared widths and state encoding for the OCI data-capture-trace sequencer.
package main_nios2_processor_oci_dct_pkg;

    localparam int ENTRY_W     = 2;
    localparam int NUM_ENTRIES = 15;
    localparam int BUF_W       = ENTRY_W * NUM_ENTRIES;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        DRAIN   = 2'd1,
        ENDED   = 2'd2
    } dct_state_e;

endpackage

// File: rtl/main_nios2_processor_oci_dct_outslot.sv
// One-word valid/ready output register between the capture buffer and the trace-memory writer.
module main_nios2_processor_oci_dct_outslot
    import main_nios2_processor_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buffer,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_buffer,
    output logic [CNT_W-1:0] out_count,
    output logic             slot_free
);

    // Handshake: a word transfers on any edge where out_valid & out_ready;
    // the word is held unchanged while out_valid & ~out_ready.
    assign slot_free = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_buffer <= '0;
            out_count  <= '0;
        end else if (load) begin
            // load is only raised when slot_free, so this never clobbers a held word
            out_valid  <= 1'b1;
            out_buffer <= load_buffer;
            out_count  <= load_count;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/main_nios2_processor_oci_dct_sequencer.sv
// Packs 2-bit trace entries into a 15-slot capture buffer, launches full or flushed
// buffers into the output slot, and runs the end-of-test drain.
module main_nios2_processor_oci_dct_sequencer
    import main_nios2_processor_oci_dct_pkg::*;
#(
    parameter int FLUSH_THRESH = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [ENTRY_W-1:0] in_entry,
    output logic               in_ready,
    input  logic               flush_req,
    input  logic               test_ending,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BUF_W-1:0]   out_buffer,
    output logic [CNT_W-1:0]   out_count,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               test_has_ended,
    output dct_state_e         dct_state
);

    dct_state_e       state, state_nxt;
    logic             flush_pend, flush_pend_nxt;
    logic             slot_free, trigger, launch, accept;
    logic [BUF_W-1:0] buf_nxt;
    logic [CNT_W-1:0] base_cnt, cnt_nxt;

    assign dct_state = state;

    // Registered-only: no combinational path from in_valid to in_ready.
    assign in_ready = (state == CAPTURE) && (dct_count < CNT_W'(NUM_ENTRIES));
    assign accept   = in_valid & in_ready;

    always_comb begin
        trigger = (dct_count >= CNT_W'(FLUSH_THRESH))
                | ((flush_req | flush_pend) & (dct_count != '0))
                | ((state == DRAIN) & (dct_count != '0));
        launch  = trigger & slot_free;
    end

    // A launch empties the buffer first, so a same-cycle accept lands in slot 0.
    always_comb begin
        buf_nxt  = launch ? '0 : dct_buffer;
        base_cnt = launch ? '0 : dct_count;
        cnt_nxt  = base_cnt;
        if (accept) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (base_cnt == CNT_W'(i)) begin
                    buf_nxt[i*ENTRY_W +: ENTRY_W] = in_entry;
                end
            end
            cnt_nxt = base_cnt + CNT_W'(1);
        end
    end

    // A flush that finds the slot busy is remembered until the buffer launches.
    always_comb begin
        flush_pend_nxt = flush_pend;
        if (launch) begin
            flush_pend_nxt = 1'b0;
        end else if (flush_req && (dct_count != '0)) begin
            flush_pend_nxt = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CAPTURE: if (test_ending) state_nxt = DRAIN;
            DRAIN:   if ((dct_count == '0) && !out_valid) state_nxt = ENDED;
            ENDED:   state_nxt = ENDED;
            default: state_nxt = CAPTURE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= CAPTURE;
            dct_buffer     <= '0;
            dct_count      <= '0;
            flush_pend     <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            state          <= state_nxt;
            dct_buffer     <= buf_nxt;
            dct_count      <= cnt_nxt;
            flush_pend     <= flush_pend_nxt;
            test_has_ended <= (state_nxt == ENDED);
        end
    end

    main_nios2_processor_oci_dct_outslot u_outslot (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (launch),
        .load_buffer (dct_buffer),
        .load_count  (dct_count),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_buffer  (out_buffer),
        .out_count   (out_count),
        .slot_free   (slot_free)
    );

endmodule

// File: tb/tb_main_nios2_processor_oci_dct_sequencer.sv
// Bench for the DCT sequencer: queue-based reference model, expected-word scoreboard, directed and random phases.
module tb_main_nios2_processor_oci_dct_sequencer;
    import main_nios2_processor_oci_dct_pkg::*;

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid = 1'b0;
    logic [ENTRY_W-1:0] in_entry = '0;
    logic               flush_req = 1'b0;
    logic               test_ending = 1'b0;
    logic               out_ready = 1'b0;
    logic               in_ready, out_valid, test_has_ended;
    logic [BUF_W-1:0]   out_buffer, dct_buffer;
    logic [CNT_W-1:0]   out_count, dct_count;
    dct_state_e         dct_state;

    always #5 clk = ~clk;

    main_nios2_processor_oci_dct_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_entry       (in_entry),
        .in_ready       (in_ready),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_buffer     (out_buffer),
        .out_count      (out_count),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended),
        .dct_state      (dct_state)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_vec++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- reference model ----------------
    // Accepted-but-unlaunched entries are a queue; a word is the queue packed low-first.
    logic [ENTRY_W-1:0]       cap_q[$];
    logic [CNT_W+BUF_W-1:0]   exp_q[$];
    bit                       m_ov    = 0;
    bit                       m_pend  = 0;
    int                       m_state = 0;   // 0 capturing, 1 draining, 2 ended

    function automatic logic [BUF_W-1:0] pack_cap();
        logic [BUF_W-1:0] w;
        w = '0;
        foreach (cap_q[i]) w = w | (BUF_W'(cap_q[i]) << (ENTRY_W * i));
        return w;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q.delete();
            exp_q.delete();
            m_ov    = 0;
            m_pend  = 0;
            m_state = 0;
        end else begin
            int  cnt;
            bit  acc, go;
            int  nxt;
            cnt = cap_q.size();
            acc = in_valid && (m_state == 0) && (cnt < NUM_ENTRIES);
            go  = (!m_ov || out_ready) &&
                  ((cnt >= NUM_ENTRIES) || ((flush_req || m_pend) && cnt > 0) || (m_state == 1 && cnt > 0));
            nxt = m_state;
            if (m_state == 0 && test_ending) nxt = 1;
            else if (m_state == 1 && cnt == 0 && !m_ov) nxt = 2;
            if (go) begin
                exp_q.push_back({CNT_W'(cnt), pack_cap()});
                cap_q.delete();
                m_ov   = 1;
                m_pend = 0;
            end else begin
                if (m_ov && out_ready) m_ov = 0;
                if (flush_req && cnt > 0) m_pend = 1;
            end
            if (acc) cap_q.push_back(in_entry);
            m_state = nxt;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit                     held_v = 0;
    logic [CNT_W+BUF_W-1:0] held_w;

    always @(negedge clk) begin
        check("in_ready", 64'(in_ready), 64'((m_state == 0) && (cap_q.size() < NUM_ENTRIES)));
        check("dct_count", 64'(dct_count), 64'(cap_q.size()));
        check("dct_buffer", 64'(dct_buffer), 64'(pack_cap()));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("test_has_ended", 64'(test_has_ended), 64'(m_state == 2));
        if (!reset_n) begin
            held_v = 0;
        end else begin
            if (held_v) check("out_stable", 64'({out_count, out_buffer}), 64'(held_w));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("out_word", "word presented with no expected word queued");
                else check("out_word", 64'({out_count, out_buffer}), 64'(exp_q.pop_front()));
            end
            held_v = out_valid && !out_ready;
            held_w = {out_count, out_buffer};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [ENTRY_W-1:0] e);
        int cyc;
        bit took;
        cyc  = 0;
        took = 0;
        in_valid = 1'b1;
        in_entry = e;
        while (!took && cyc < 50) begin
            took = in_ready;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        if (!took) fail_now("put_timeout", "entry not accepted within 50 cycles");
    endtask

    task automatic reset_dut();
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        flush_req   = 1'b0;
        test_ending = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        out_ready = 1'b1;
        step();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_buffer", 64'(out_buffer), 64'(0));
        check("rst_out_count", 64'(out_count), 64'(0));
        check("rst_dct_count", 64'(dct_count), 64'(0));
        check("rst_ended", 64'(test_has_ended), 64'(0));
        step();
        reset_n = 1'b1;

        // full buffer of 2'b01 launches one edge after the 15th accept
        for (int i = 0; i < 15; i++) put(2'b01);
        check("t1_no_early_valid", 64'(out_valid), 64'(0));
        check("t1_count_full", 64'(dct_count), 64'(15));
        step();
        check("t1_valid", 64'(out_valid), 64'(1));
        check("t1_buffer", 64'(out_buffer), 64'(30'h15555555));
        check("t1_count", 64'(out_count), 64'(15));
        check("t1_dct_count", 64'(dct_count), 64'(0));
        step();

        // partial flush, then a flush of an empty buffer
        put(2'b11); put(2'b10); put(2'b01);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("t2_valid", 64'(out_valid), 64'(1));
        check("t2_buffer", 64'(out_buffer), 64'(30'h0000001B));
        check("t2_count", 64'(out_count), 64'(3));
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("t2_empty_flush", 64'(out_valid), 64'(0));
        step();
        check("t2_empty_flush2", 64'(out_valid), 64'(0));

        // backpressure: 30 entries with the writer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) put(ENTRY_W'($urandom_range(0, 3)));
        check("t3_in_ready_low", 64'(in_ready), 64'(0));
        check("t3_out_valid", 64'(out_valid), 64'(1));
        check("t3_dct_full", 64'(dct_count), 64'(15));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_entry = ENTRY_W'($urandom_range(0, 3));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("t3_drained_valid", 64'(out_valid), 64'(0));
        check("t3_drained_count", 64'(dct_count), 64'(0));

        // launch with a same-cycle accept
        for (int i = 0; i < 4; i++) put(2'b11);
        in_valid  = 1'b1;
        in_entry  = 2'b10;
        flush_req = 1'b1;
        step();
        in_valid  = 1'b0;
        flush_req = 1'b0;
        check("t4_valid", 64'(out_valid), 64'(1));
        check("t4_buffer", 64'(out_buffer), 64'(30'hFF));
        check("t4_count", 64'(out_count), 64'(4));
        check("t4_dct_count", 64'(dct_count), 64'(1));
        check("t4_dct_buffer", 64'(dct_buffer), 64'(30'h2));
        step();

        // randomized traffic with varying writer stall density
        for (int blk = 0; blk < 8; blk++) begin
            int stall;
            stall = $urandom_range(0, 3);
            for (int i = 0; i < 50; i++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_entry  = ENTRY_W'($urandom_range(0, 3));
                out_ready = ($urandom_range(0, 3) >= stall);
                flush_req = ($urandom_range(0, 19) == 0);
                step();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("rnd_clean_count", 64'(dct_count), 64'(0));
        check("rnd_clean_valid", 64'(out_valid), 64'(0));

        // end-of-test drain of a 5-entry partial buffer
        for (int i = 0; i < 5; i++) put(ENTRY_W'($urandom_range(0, 3)));
        test_ending = 1'b1;
        step();
        check("t5_in_ready", 64'(in_ready), 64'(0));
        step();
        test_ending = 1'b0;
        check("t5_valid", 64'(out_valid), 64'(1));
        check("t5_count", 64'(out_count), 64'(5));
        for (int i = 0; i < 10 && !test_has_ended; i++) step();
        check("t5_ended", 64'(test_has_ended), 64'(1));
        for (int i = 0; i < 3; i++) step();
        check("t5_sticky", 64'(test_has_ended), 64'(1));

        // end of test with nothing captured
        reset_dut();
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        check("t6_not_yet", 64'(test_has_ended), 64'(0));
        step();
        check("t6_ended", 64'(test_has_ended), 64'(1));

        // asynchronous reset with a held word and a pending flush
        reset_dut();
        out_ready = 1'b0;
        put(2'b01); put(2'b10); put(2'b11);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        check("t7_word_held", 64'(out_valid), 64'(1));
        put(2'b11); put(2'b01);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        @(posedge clk);
        #3;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t7_out_valid", 64'(out_valid), 64'(0));
        check("t7_out_buffer", 64'(out_buffer), 64'(0));
        check("t7_out_count", 64'(out_count), 64'(0));
        check("t7_dct_count", 64'(dct_count), 64'(0));
        check("t7_dct_buffer", 64'(dct_buffer), 64'(0));
        check("t7_in_ready", 64'(in_ready), 64'(1));
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t7_no_emit", 64'(out_valid), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
